// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ctrl data-memory controller.
// The parity helper is only referenced when DMEM_CTRL_PARITY_EN is defined.
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Even parity: the returned bit makes the total count of ones across byte plus bit even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
// Optional even-parity columns (one bit per byte) when DMEM_CTRL_PARITY_EN is defined.
import dmem_pkg::*;

module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
`ifdef DMEM_CTRL_PARITY_EN
    input  logic                par_inv,
    output logic                par_err,
`endif
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

`ifdef DMEM_CTRL_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_mismatch;

    always_comb begin
        rd_mismatch = '0;
        for (int i = 0; i < NB; i++) begin
            rd_mismatch[i] = byte_parity(mem[idx][i*8 +: 8]) ^ par_mem[idx][i];
        end
    end

    // Parity is written alongside each enabled byte; par_inv deliberately corrupts it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par_mem[idx][i] <= byte_parity(wdata[i*8 +: 8]) ^ par_inv;
                end
            end
        end
        if (rd_en) begin
            par_err <= |rd_mismatch;
        end
    end
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, WAIT_STATES latency, byte enables, error response.
// Optional per-byte parity and par_inject port when DMEM_CTRL_PARITY_EN is defined.
import dmem_pkg::*;

module dmem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enable,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_CTRL_PARITY_EN
    input  logic                par_inject,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic                  accept;
    logic                  enter_resp;

    logic                  lat_write;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DATA_W-1:0]     lat_wdata;
    logic [NB-1:0]         lat_be;

    logic                  cur_write;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     cur_wdata;
    logic [NB-1:0]         cur_be;
    logic                  in_range;

    logic                  rsp_zero_q;
    logic                  rsp_err_q;
    logic [DATA_W-1:0]     arr_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Every transition is gated by clk_enable so a frozen controller holds state and outputs.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_ready    = 1'b0;
        accept       = 1'b0;
        enter_resp   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = clk_enable;
                if (clk_enable && req_valid && !rst) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (clk_enable && !rst) begin
                    if (wait_cnt == '0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt - WAIT_CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (clk_enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // With zero wait states the commit happens on the accept edge, so the live request is used in IDLE.
    always_comb begin
        cur_write = (state == IDLE) ? req_write : lat_write;
        cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
        cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        cur_be    = (state == IDLE) ? req_be    : lat_be;
        in_range  = int'(cur_addr) < DEPTH;
    end

`ifdef DMEM_CTRL_PARITY_EN
    logic lat_par_inject;
    logic cur_par_inject;
    logic arr_par_err;

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_par_inject <= par_inject;
        end
    end

    assign cur_par_inject = (state == IDLE) ? par_inject : lat_par_inject;
`endif

    // rsp_zero_q masks the array read register for store and out-of-range responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero_q <= 1'b1;
            rsp_err_q  <= 1'b0;
        end else if (enter_resp) begin
            rsp_zero_q <= cur_write | ~in_range;
            rsp_err_q  <= ~in_range;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (enter_resp & cur_write & in_range),
        .rd_en   (enter_resp & ~cur_write & in_range),
        .idx     (cur_addr[IDX_W-1:0]),
        .wdata   (cur_wdata),
        .be      (cur_be),
`ifdef DMEM_CTRL_PARITY_EN
        .par_inv (cur_par_inject),
        .par_err (arr_par_err),
`endif
        .rdata   (arr_rdata)
    );

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_zero_q ? '0 : arr_rdata;
`ifdef DMEM_CTRL_PARITY_EN
    assign rsp_err   = rsp_err_q | (~rsp_zero_q & arr_par_err);
`else
    assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (WS=0/DEPTH=200, WS=3, WS=2).
// Parity checks are included when DMEM_CTRL_PARITY_EN is defined.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        clk_enable [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [7:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        rsp_err    [3];
`ifdef DMEM_CTRL_PARITY_EN
    logic        par_inject [3];
    logic        inj_sel;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_ctrl #(
            .ADDR_W      (8),
            .DATA_W      (32),
            .DEPTH       (g == 0 ? 200 : 256),
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .clk_enable (clk_enable[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
`ifdef DMEM_CTRL_PARITY_EN
            .par_inject (par_inject[g]),
`endif
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One request on instance d; abort pulses rst in the first post-accept cycle, hold freezes clk_enable.
    task automatic applyStimulus(input int d, input string tag, input logic wr, input logic [7:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input bit abort,
                                 input int hold, input int exp_lat, input logic [31:0] exp_rdata,
                                 input logic exp_err);
        int lat;
        int seen;
        @(negedge clk);
        checkOutput({tag, ".ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
`ifdef DMEM_CTRL_PARITY_EN
        par_inject[d] = inj_sel;
`endif
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        if (abort) begin
            rst[d] = 1'b1;
            @(negedge clk);
            rst[d] = 1'b0;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (rsp_valid[d]) seen++;
            end
            checkOutput({tag, ".norsp"}, 32'(seen), 32'd0);
        end else begin
            if (hold > 0) begin
                clk_enable[d] = 1'b0;
                repeat (hold) @(negedge clk);
                clk_enable[d] = 1'b1;
                lat += hold;
            end
            while (!rsp_valid[d] && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checkOutput({tag, ".lat"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, ".rdata"}, rsp_rdata[d], exp_rdata);
            checkOutput({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
            @(negedge clk);
            checkOutput({tag, ".strobe"}, 32'(rsp_valid[d]), 32'd0);
            checkOutput({tag, ".hold"}, rsp_rdata[d], exp_rdata);
        end
    endtask

    initial begin
        int seen;
        for (int d = 0; d < 3; d++) begin
            rst[d]        = 1'b1;
            clk_enable[d] = 1'b1;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_be[d]     = '0;
`ifdef DMEM_CTRL_PARITY_EN
            par_inject[d] = 1'b0;
`endif
        end
`ifdef DMEM_CTRL_PARITY_EN
        inj_sel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset%0d.ready", d), 32'(req_ready[d]), 32'd1);
            checkOutput($sformatf("reset%0d.valid", d), 32'(rsp_valid[d]), 32'd0);
            checkOutput($sformatf("reset%0d.rdata", d), rsp_rdata[d], 32'd0);
            checkOutput($sformatf("reset%0d.err", d), 32'(rsp_err[d]), 32'd0);
        end

        $display("[TB] zero wait states, DEPTH=200");
        applyStimulus(0, "st10",  1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1, 32'h0,        1'b0);
        applyStimulus(0, "ld10",  1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 0, 1, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, "stbe0", 1'b1, 8'h10, 32'h00000000, 4'h0, 1'b0, 0, 1, 32'h0,        1'b0);
        applyStimulus(0, "ld10b", 1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 0, 1, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, "st50",  1'b1, 8'd50, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1, 32'h0,        1'b0);
        applyStimulus(0, "ld250", 1'b0, 8'd250, 32'h0,       4'h0, 1'b0, 0, 1, 32'h0,        1'b1);
        applyStimulus(0, "st250", 1'b1, 8'd250, 32'h55555555, 4'hF, 1'b0, 0, 1, 32'h0,       1'b1);
        applyStimulus(0, "ld50",  1'b0, 8'd50, 32'h0,        4'h0, 1'b0, 0, 1, 32'hCAFEF00D, 1'b0);
        applyStimulus(0, "ld199", 1'b0, 8'd199, 32'h0,       4'h0, 1'b0, 0, 1, 32'h0,        1'b0);
        applyStimulus(0, "ld200", 1'b0, 8'd200, 32'h0,      4'h0, 1'b0, 0, 1, 32'h0,        1'b1);

        // A request presented during reset, then one presented while frozen, must both be ignored.
        @(negedge clk);
        rst[0]       = 1'b1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 8'h10;
        @(negedge clk);
        rst[0]       = 1'b0;
        req_valid[0] = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        checkOutput("rstreq.norsp", 32'(seen), 32'd0);
        clk_enable[0] = 1'b0;
        req_valid[0]  = 1'b1;
        #1;
        checkOutput("freeze.ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        clk_enable[0] = 1'b1;
        req_valid[0]  = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        checkOutput("freeze.norsp", 32'(seen), 32'd0);

        $display("[TB] three wait states");
        applyStimulus(1, "st5a", 1'b1, 8'd5, 32'hFFFFFFFF, 4'hF,    1'b0, 0, 4, 32'h0,        1'b0);
        applyStimulus(1, "st5b", 1'b1, 8'd5, 32'h11223344, 4'b0101, 1'b0, 0, 4, 32'h0,        1'b0);
        applyStimulus(1, "ld5",  1'b0, 8'd5, 32'h0,        4'h0,    1'b0, 0, 4, 32'hFF22FF44, 1'b0);

        $display("[TB] two wait states, abort and freeze");
        applyStimulus(2, "st20",   1'b1, 8'h20, 32'h0BADF00D, 4'hF, 1'b0, 0, 3, 32'h0,        1'b0);
        applyStimulus(2, "abort",  1'b1, 8'h20, 32'h12345678, 4'hF, 1'b1, 0, 0, 32'h0,        1'b0);
        applyStimulus(2, "ld20",   1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 0, 3, 32'h0BADF00D, 1'b0);
        applyStimulus(2, "ld20fz", 1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 5, 8, 32'h0BADF00D, 1'b0);

`ifdef DMEM_CTRL_PARITY_EN
        $display("[TB] parity");
        inj_sel = 1'b1;
        applyStimulus(0, "pst7", 1'b1, 8'd7, 32'hA5A5A5A5, 4'hF, 1'b0, 0, 1, 32'h0,        1'b0);
        inj_sel = 1'b0;
        applyStimulus(0, "pld7", 1'b0, 8'd7, 32'h0,        4'h0, 1'b0, 0, 1, 32'hA5A5A5A5, 1'b1);
        applyStimulus(0, "pst8", 1'b1, 8'd8, 32'h5A5A5A5A, 4'hF, 1'b0, 0, 1, 32'h0,        1'b0);
        applyStimulus(0, "pld8", 1'b0, 8'd8, 32'h0,        4'h0, 1'b0, 0, 1, 32'h5A5A5A5A, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
